// File: rtl/dx_iobus_ctrl.sv
// Half-duplex controller for a shared tri-state bus behind dx_iobuf.
// Round-robin write/read arbitration, turnaround gaps on direction change, fixed-latency read capture.
module dx_iobus_ctrl #(
    parameter int DATA_WIDTH  = 8,
    parameter int TURN_CYCLES = 2,
    parameter int RD_LAT      = 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  wr_valid,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_ready,
    input  logic                  rd_valid,
    output logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_data_valid,
    output logic                  bus_stb,
    output logic                  bus_we,
    output logic [DATA_WIDTH-1:0] dio_t,
    output logic [DATA_WIDTH-1:0] dio_o,
    input  logic [DATA_WIDTH-1:0] dio_i
);

    typedef enum logic [2:0] {IDLE, TURN, WR, RD, RD_WAIT} state_t;

    localparam int CNT_MAX = (TURN_CYCLES > RD_LAT) ? TURN_CYCLES : RD_LAT;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CW-1:0] TURN_LAST = CW'((TURN_CYCLES > 0) ? TURN_CYCLES - 1 : 0);
    localparam logic [CW-1:0] RD_LAST   = CW'(RD_LAT - 1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic          dir_drv;   // 1 = we own the bus
    logic          last_wr;   // 1 = write was served last
    logic          released;  // registered tri-state control, replicated to every bit

    logic gnt_wr, gnt_rd, need_turn;

    // Round robin: a lone requester wins; on a tie the one not served last wins.
    assign gnt_wr    = wr_valid && (!rd_valid || !last_wr);
    assign gnt_rd    = rd_valid && (!wr_valid ||  last_wr);
    assign need_turn = (gnt_wr && !dir_drv) || (gnt_rd && dir_drv);

    assign wr_ready = (state == IDLE) && gnt_wr &&  dir_drv;
    assign rd_ready = (state == IDLE) && gnt_rd && !dir_drv;
    assign dio_t    = {DATA_WIDTH{released}};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state         <= IDLE;
            cnt           <= '0;
            dir_drv       <= 1'b0;
            last_wr       <= 1'b0;
            released      <= 1'b1;
            dio_o         <= '0;
            bus_stb       <= 1'b0;
            bus_we        <= 1'b0;
            rd_data       <= '0;
            rd_data_valid <= 1'b0;
        end else begin
            bus_stb       <= 1'b0;
            rd_data_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (wr_ready) begin
                        state    <= WR;
                        dio_o    <= wr_data;
                        released <= 1'b0;
                        bus_stb  <= 1'b1;
                        bus_we   <= 1'b1;
                        last_wr  <= 1'b1;
                    end else if (rd_ready) begin
                        state   <= RD;
                        cnt     <= '0;
                        bus_stb <= 1'b1;
                        bus_we  <= 1'b0;
                        last_wr <= 1'b0;
                    end else if (need_turn) begin
                        // Let go of the pads first; direction flips only after the gap.
                        released <= 1'b1;
                        if (TURN_CYCLES == 0) begin
                            dir_drv <= !dir_drv;
                        end else begin
                            state <= TURN;
                            cnt   <= '0;
                        end
                    end
                end
                TURN: begin
                    if (cnt == TURN_LAST) begin
                        dir_drv <= !dir_drv;
                        state   <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WR: state <= IDLE;
                RD: state <= RD_WAIT;
                RD_WAIT: begin
                    if (cnt == RD_LAST) begin
                        rd_data       <= dio_i;
                        rd_data_valid <= 1'b1;
                        state         <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dx_iobus_ctrl.sv
// Bench for dx_iobus_ctrl: directed vector table, corner sequences, and random traffic
// checked against a transaction-level reference model.
module tb_dx_iobus_ctrl;

    localparam int DW = 8;
    localparam int TC = 2;
    localparam int RL = 1;

    logic          clk = 1'b0;
    logic          rstn;
    logic          wr_valid, wr_ready, rd_valid, rd_ready, rd_data_valid, bus_stb, bus_we;
    logic [DW-1:0] wr_data, rd_data, dio_t, dio_o, dio_i;

    always #5 clk = ~clk;

    dx_iobus_ctrl #(.DATA_WIDTH(DW), .TURN_CYCLES(TC), .RD_LAT(RL)) dut (
        .clk(clk), .rstn(rstn),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
        .rd_valid(rd_valid), .rd_ready(rd_ready),
        .rd_data(rd_data), .rd_data_valid(rd_data_valid),
        .bus_stb(bus_stb), .bus_we(bus_we),
        .dio_t(dio_t), .dio_o(dio_o), .dio_i(dio_i)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk1(input string n, input logic a, input logic e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s: got %b, want %b at %0t", n, a, e, $time);
        end
    endtask

    task automatic chk8(input string n, input logic [DW-1:0] a, input logic [DW-1:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s: got %h, want %h at %0t", n, a, e, $time);
        end
    endtask

    task automatic chk_int(input string n, input int a, input int e);
        checks++;
        if (a != e) begin
            failures++;
            $display("FAIL %s: got %0d, want %0d at %0t", n, a, e, $time);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    logic          m_dir, m_last;          // m_dir 1 = controller drives; m_last 1 = write served last
    int            m_busy, m_turn, m_cyc;  // cycles left in current transfer / turnaround
    logic          e_stb, e_we, e_rdv, e_rel;
    logic [DW-1:0] e_do, e_rd;
    int            cap_q[$];               // cycle numbers at which a read is captured
    int            stb_seen = 0, hs_cnt = 0;

    task automatic model_reset();
        m_dir = 1'b0; m_last = 1'b0; m_busy = 0; m_turn = 0; m_cyc = 0;
        e_stb = 1'b0; e_we = 1'b0; e_rdv = 1'b0; e_rel = 1'b1;
        e_do = '0; e_rd = '0;
        cap_q.delete();
    endtask

    task automatic cycle(input logic wv, input logic [DW-1:0] wd, input logic rv,
                         input logic [DW-1:0] di, output logic hw, output logic hr);
        logic idle, gw, gr, ew, er;
        @(negedge clk);
        wr_valid = wv; wr_data = wd; rd_valid = rv; dio_i = di;
        #1;
        chk1("bus_stb", bus_stb, e_stb);
        if (e_stb) chk1("bus_we", bus_we, e_we);
        chk8("dio_t", dio_t, {DW{e_rel}});
        chk8("dio_o", dio_o, e_do);
        chk1("rd_data_valid", rd_data_valid, e_rdv);
        chk8("rd_data", rd_data, e_rd);
        if (cap_q.size() > 0) chk8("no_contention", dio_t, {DW{1'b1}});
        if (bus_stb) stb_seen++;
        idle = (m_busy == 0) && (m_turn == 0);
        gw   = wv && (!rv || !m_last);
        gr   = rv && (!wv ||  m_last);
        ew   = idle && gw &&  m_dir;
        er   = idle && gr && !m_dir;
        chk1("wr_ready", wr_ready, ew);
        chk1("rd_ready", rd_ready, er);
        chk1("ready_excl", wr_ready && rd_ready, 1'b0);
        hw = wv && wr_ready;
        hr = rv && rd_ready;
        if (hw || hr) hs_cnt++;
        @(posedge clk);
        e_stb = 1'b0;
        e_rdv = 1'b0;
        if (cap_q.size() > 0 && cap_q[0] == m_cyc) begin
            void'(cap_q.pop_front());
            e_rdv = 1'b1;
            e_rd  = di;
        end
        if (!idle) begin
            if (m_busy > 0) m_busy--;
            else begin
                m_turn--;
                if (m_turn == 0) m_dir = !m_dir;
            end
        end else if (ew) begin
            m_busy = 1; m_last = 1'b1; e_stb = 1'b1; e_we = 1'b1; e_do = wd; e_rel = 1'b0;
        end else if (er) begin
            m_busy = RL + 1; m_last = 1'b0; e_stb = 1'b1; e_we = 1'b0;
            cap_q.push_back(m_cyc + RL + 1);
        end else if (gw || gr) begin
            if (m_dir) e_rel = 1'b1;
            if (TC == 0) m_dir = !m_dir;
            else m_turn = TC;
        end
        m_cyc++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0; wr_valid = 1'b0; rd_valid = 1'b0;
        #1;
        chk8("rst.dio_t", dio_t, {DW{1'b1}});
        chk1("rst.bus_stb", bus_stb, 1'b0);
        chk1("rst.rd_data_valid", rd_data_valid, 1'b0);
        chk8("rst.rd_data", rd_data, '0);
        chk1("rst.wr_ready", wr_ready, 1'b0);
        chk1("rst.rd_ready", rd_ready, 1'b0);
        @(negedge clk);
        rstn = 1'b1;
        model_reset();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic          wv;
        logic [DW-1:0] wd;
        logic          rv;
        logic [DW-1:0] di;
        logic          wrdy, rrdy, stb, we;
        logic [DW-1:0] dt, dout;
        logic          rdv;
        logic [DW-1:0] rdd;
    } vec_t;

    vec_t tbl[13];

    function automatic vec_t mk(logic wv, logic [DW-1:0] wd, logic rv, logic [DW-1:0] di,
                                logic wrdy, logic rrdy, logic stb, logic we,
                                logic [DW-1:0] dt, logic [DW-1:0] dout, logic rdv, logic [DW-1:0] rdd);
        vec_t v;
        v.wv = wv; v.wd = wd; v.rv = rv; v.di = di;
        v.wrdy = wrdy; v.rrdy = rrdy; v.stb = stb; v.we = we;
        v.dt = dt; v.dout = dout; v.rdv = rdv; v.rdd = rdd;
        return v;
    endfunction

    logic          hw, hr, prev_w;
    logic [DW-1:0] wseq[3];
    int            k, last_hs, n;

    initial begin
        rstn = 1'b0; wr_valid = 1'b0; wr_data = '0; rd_valid = 1'b0; dio_i = '0;
        model_reset();

        // write from reset (decide + 2 turn), then read with turnaround, far end returns 3C
        tbl[0]  = mk(1'b1, 8'hA5, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFF, 8'h00, 1'b0, 8'h00);
        tbl[1]  = mk(1'b1, 8'hA5, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFF, 8'h00, 1'b0, 8'h00);
        tbl[2]  = mk(1'b1, 8'hA5, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFF, 8'h00, 1'b0, 8'h00);
        tbl[3]  = mk(1'b1, 8'hA5, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'hFF, 8'h00, 1'b0, 8'h00);
        tbl[4]  = mk(1'b0, 8'h00, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'hA5, 1'b0, 8'h00);
        tbl[5]  = mk(1'b0, 8'h00, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'hA5, 1'b0, 8'h00);
        tbl[6]  = mk(1'b0, 8'h00, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFF, 8'hA5, 1'b0, 8'h00);
        tbl[7]  = mk(1'b0, 8'h00, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFF, 8'hA5, 1'b0, 8'h00);
        tbl[8]  = mk(1'b0, 8'h00, 1'b1, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0, 8'hFF, 8'hA5, 1'b0, 8'h00);
        tbl[9]  = mk(1'b0, 8'h00, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, 8'hFF, 8'hA5, 1'b0, 8'h00);
        tbl[10] = mk(1'b0, 8'h00, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFF, 8'hA5, 1'b0, 8'h00);
        tbl[11] = mk(1'b0, 8'h00, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFF, 8'hA5, 1'b1, 8'h3C);
        tbl[12] = mk(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFF, 8'hA5, 1'b0, 8'h3C);

        do_reset();
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            wr_valid = tbl[i].wv; wr_data = tbl[i].wd; rd_valid = tbl[i].rv; dio_i = tbl[i].di;
            #1;
            chk1($sformatf("tbl%0d.wr_ready", i), wr_ready, tbl[i].wrdy);
            chk1($sformatf("tbl%0d.rd_ready", i), rd_ready, tbl[i].rrdy);
            chk1($sformatf("tbl%0d.bus_stb", i), bus_stb, tbl[i].stb);
            if (tbl[i].stb) chk1($sformatf("tbl%0d.bus_we", i), bus_we, tbl[i].we);
            chk8($sformatf("tbl%0d.dio_t", i), dio_t, tbl[i].dt);
            chk8($sformatf("tbl%0d.dio_o", i), dio_o, tbl[i].dout);
            chk1($sformatf("tbl%0d.rd_data_valid", i), rd_data_valid, tbl[i].rdv);
            chk8($sformatf("tbl%0d.rd_data", i), rd_data, tbl[i].rdd);
        end

        // single read right after reset: no turnaround
        do_reset();
        cycle(1'b0, 8'h00, 1'b1, 8'hC3, hw, hr);
        chk1("rd_first_cycle", hr, 1'b1);
        for (int c = 0; c < 4; c++) cycle(1'b0, 8'h00, 1'b0, 8'hC3, hw, hr);

        // back-to-back writes
        wseq[0] = 8'h01; wseq[1] = 8'h02; wseq[2] = 8'h03;
        k = 0; last_hs = -1;
        for (int c = 0; c < 20 && k < 3; c++) begin
            cycle(1'b1, wseq[k], 1'b0, 8'h00, hw, hr);
            if (hw) begin
                if (k > 0) chk_int("wr_spacing", c - last_hs, 2);
                last_hs = c;
                k++;
            end
        end
        chk_int("b2b_count", k, 3);
        for (int c = 0; c < 3; c++) cycle(1'b0, 8'h00, 1'b0, 8'h00, hw, hr);
        do_reset();

        // both requesters continuously valid: grants alternate
        n = 0; prev_w = 1'b0;
        for (int c = 0; c < 30; c++) begin
            cycle(1'b1, 8'($urandom), 1'b1, 8'($urandom), hw, hr);
            if (hw || hr) begin
                if (n > 0) chk1("alternate", hw, !prev_w);
                prev_w = hw;
                n++;
            end
        end
        chk1("alt_count", n >= 4, 1'b1);
        for (int c = 0; c < 4; c++) cycle(1'b0, 8'h00, 1'b0, 8'h00, hw, hr);

        // reset during RD_WAIT drops the read
        hr = 1'b0;
        for (int c = 0; c < 10 && !hr; c++) cycle(1'b0, 8'h00, 1'b1, 8'h77, hw, hr);
        chk1("rd_accept_before_reset", hr, 1'b1);
        cycle(1'b0, 8'h00, 1'b0, 8'h77, hw, hr);
        do_reset();
        for (int c = 0; c < 4; c++) cycle(1'b0, 8'h00, 1'b0, 8'h77, hw, hr);
        cycle(1'b0, 8'h00, 1'b1, 8'h55, hw, hr);
        chk1("rd_after_reset", hr, 1'b1);
        for (int c = 0; c < 4; c++) cycle(1'b0, 8'h00, 1'b0, 8'h55, hw, hr);

        // random traffic against the model
        for (int c = 0; c < 400; c++)
            cycle($urandom_range(0, 2) != 0, 8'($urandom), $urandom_range(0, 2) != 0, 8'($urandom), hw, hr);
        for (int c = 0; c < 6; c++) cycle(1'b0, 8'h00, 1'b0, 8'($urandom), hw, hr);
        chk_int("stb_count", stb_seen, hs_cnt);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
